// File: rtl/core_pkg.sv
// Shared definitions for the partial-sum collector: array geometry defaults,
// SRAM address width and the run-control state encoding.
package core_pkg;

   localparam int unsigned COL     = 8;
   localparam int unsigned PSUM_BW = 16;
   localparam int unsigned ADDR_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/psum_collector_if.sv
// Column partial-sum bus between the systolic array (master) and the collector (slave).
interface psum_collector_if #(
   parameter int unsigned COL     = core_pkg::COL,
   parameter int unsigned PSUM_BW = core_pkg::PSUM_BW
);

   logic [COL-1:0]         col_valid;
   logic [COL*PSUM_BW-1:0] col_psum;
   logic [COL-1:0]         col_ready;

   modport master (output col_valid, output col_psum, input col_ready);
   modport slave  (input col_valid, input col_psum, output col_ready);

endinterface

// File: rtl/psum_collector_col_fifo.sv
// Single-clock FIFO buffering one column's partial sums; DEPTH must be a power of two.
module col_fifo #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_c,
   output logic         full_c,
   output logic         empty_c
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;

   assign full_c  = (cnt_q == FULL_CNT);
   assign empty_c = (cnt_q == '0);
   assign rdata_c = mem_q[rd_q];

   // Storage needs no reset: emptiness is tracked by the counter alone.
   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= wdata_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + AW'(1);
         if (pop_i)  rd_q <= rd_q + AW'(1);
         case ({push_i, pop_i})
            2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
            2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/psum_collector.sv
// Collects per-column partial sums into FIFOs and writes full rows to the output SRAM.
// Define PSUM_RELU_EN to clamp negative column values to zero on the way out.
module psum_collector #(
   parameter int unsigned COL      = core_pkg::COL,
   parameter int unsigned PSUM_BW  = core_pkg::PSUM_BW,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned NUM_ROWS = 16
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          host_sel,
   psum_collector_if.slave               col_bus,
   output logic                          overflow,
   output logic                          o_cen,
   output logic                          o_wen,
   output logic [core_pkg::ADDR_W-1:0]   o_addr,
   output logic [COL*PSUM_BW-1:0]        o_d,
   output logic                          busy,
   output logic                          done
);
   import core_pkg::*;

   localparam int unsigned       DW        = COL * PSUM_BW;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROWS - 1);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d, o_addr_q;
   logic                overflow_q, overflow_d;
   logic                o_cen_q, o_wen_q, busy_q, done_q;
   logic [DW-1:0]       o_d_q, row_c;
   logic [COL-1:0]      full_c, empty_c, push_c;
   logic [PSUM_BW-1:0]  rdata_c [COL];
   logic                pop_c, drop_c;

   // A row leaves only when every column has data and the host does not own the SRAM.
   assign pop_c  = (state_q == RUN) && (empty_c == '0) && !host_sel;
   assign push_c = col_bus.col_valid & (~full_c | {COL{pop_c}});
   assign drop_c = |(col_bus.col_valid & full_c & ~{COL{pop_c}});
   assign col_bus.col_ready = ~full_c;

   for (genvar c = 0; c < COL; c++) begin : g_col
      col_fifo #(.W(PSUM_BW), .DEPTH(DEPTH)) u_fifo (
         .clk     (clk),
         .rst_n   (reset),
         .push_i  (push_c[c]),
         .pop_i   (pop_c),
         .wdata_i (col_bus.col_psum[c*PSUM_BW +: PSUM_BW]),
         .rdata_c (rdata_c[c]),
         .full_c  (full_c[c]),
         .empty_c (empty_c[c])
      );
   end

   always_comb begin
      row_c = '0;
      for (int unsigned c = 0; c < COL; c++) begin
`ifdef PSUM_RELU_EN
         row_c[c*PSUM_BW +: PSUM_BW] = rdata_c[c][PSUM_BW-1] ? '0 : rdata_c[c];
`else
         row_c[c*PSUM_BW +: PSUM_BW] = rdata_c[c];
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d    = RUN;
               cnt_d      = '0;
               overflow_d = 1'b0;
            end
         end
         RUN: begin
            if (pop_c) begin
               cnt_d = cnt_q + ADDR_W'(1);
               if (cnt_q == LAST_ADDR) state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A drop on the same edge as an accepted start still counts.
      if (drop_c) overflow_d = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         o_cen_q    <= 1'b1;
         o_wen_q    <= 1'b1;
         o_addr_q   <= '0;
         o_d_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         o_cen_q    <= !pop_c;
         o_wen_q    <= !pop_c;
         if (pop_c) begin
            o_addr_q <= cnt_q;
            o_d_q    <= row_c;
         end
         busy_q     <= (state_d == RUN);
         done_q     <= (state_d == DONE);
      end
   end

   assign overflow = overflow_q;
   assign o_cen    = o_cen_q;
   assign o_wen    = o_wen_q;
   assign o_addr   = o_addr_q;
   assign o_d      = o_d_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
